// File: rtl/dct_mac_pipe.sv
// dct_mac_pipe: pipelined signed MAC for the forward-DCT datapath.
// Accumulates TAPS sample*coefficient products per block, then rounds,
// shifts and saturates the sum into one OUT_W-bit result per block.
// Pipeline: product -> accumulate -> round/shift -> saturate/output.
module dct_mac_pipe #(
    parameter int DW    = 8,
    parameter int CW    = 12,
    parameter int TAPS  = 8,
    parameter int SHIFT = 8,
    parameter int OUT_W = 12,
    parameter int ROUND = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic signed [DW-1:0]    din,
    input  logic signed [CW-1:0]    coef,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);

    localparam int PW    = DW + CW;
    localparam int ACC_W = PW + $clog2(TAPS);
    // One spare bit so adding the rounding constant can never wrap.
    localparam int RW    = ACC_W + 1;
    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);
    localparam logic signed [RW-1:0] RND_C =
        (ROUND != 0) ? (RW'(1) <<< (SHIFT - 1)) : '0;
    localparam logic signed [RW-1:0] MAXV =
        {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [RW-1:0] MINV =
        {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Term counter; clr restarts the block before the incoming term is counted.
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

    // Stage 1: registered product and its block-position tags.
    logic                 v1_q, first1_q, last1_q;
    logic                 v1_d, first1_d, last1_d;
    logic signed [PW-1:0] mult_res_q, mult_res_d, prod;

    // Stage 2: accumulator and block-complete flag.
    logic                    done_q, done_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, prod_ext;

    // Stage 3a: rounded and shifted sum.
    logic                 sv_q;
    logic signed [RW-1:0] sh_q, sh_d, rnd;

    // Stage 3b: saturated result.
    logic                    out_valid_q;
    logic signed [OUT_W-1:0] dout_q, dout_d;
    logic                    ovf_q, ovf_d;

    assign cnt_base = clr ? '0 : cnt_q;
    assign prod     = PW'(din) * PW'(coef);
    assign prod_ext = ACC_W'(mult_res_q);
    assign rnd      = RW'(acc_q) + RND_C;

    // Next-state for the counter and stage-1 tags.
    always_comb begin
        cnt_d      = cnt_base;
        v1_d       = in_valid;
        first1_d   = in_valid && (cnt_base == '0);
        last1_d    = in_valid && (cnt_base == LAST_CNT);
        mult_res_d = mult_res_q;
        if (in_valid) begin
            cnt_d      = (cnt_base == LAST_CNT) ? '0 : cnt_base + 1'b1;
            mult_res_d = prod;
        end
    end

    // Next-state for the accumulator: a first term loads, later terms add,
    // and clr drops whatever stage 1 was holding.
    always_comb begin
        acc_d  = acc_q;
        done_d = v1_q && last1_q && !clr;
        if (v1_q && !clr)
            acc_d = first1_q ? prod_ext : acc_q + prod_ext;
    end

    // Next-state for the rounding and saturation stages.
    always_comb begin
        sh_d   = done_q ? (rnd >>> SHIFT) : sh_q;
        dout_d = dout_q;
        ovf_d  = ovf_q;
        if (sv_q) begin
            if (sh_q > MAXV) begin
                dout_d = MAXV[OUT_W-1:0];
                ovf_d  = 1'b1;
            end else if (sh_q < MINV) begin
                dout_d = MINV[OUT_W-1:0];
                ovf_d  = 1'b1;
            end else begin
                dout_d = sh_q[OUT_W-1:0];
                ovf_d  = 1'b0;
            end
        end
    end

    // Counter and stage-1 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            v1_q       <= 1'b0;
            first1_q   <= 1'b0;
            last1_q    <= 1'b0;
            mult_res_q <= '0;
        end else if (ena) begin
            cnt_q      <= cnt_d;
            v1_q       <= v1_d;
            first1_q   <= first1_d;
            last1_q    <= last1_d;
            mult_res_q <= mult_res_d;
        end
    end

    // Stage-2 accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            done_q <= 1'b0;
        end else if (ena) begin
            acc_q  <= acc_d;
            done_q <= done_d;
        end
    end

    // Stage-3 round/shift and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sv_q        <= 1'b0;
            sh_q        <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (ena) begin
            sv_q        <= done_q;
            sh_q        <= sh_d;
            out_valid_q <= sv_q;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dct_mac_pipe.sv
// Bench for dct_mac_pipe: directed scenarios plus a randomized stream
// checked against a block-level arithmetic model. A second instance
// with ROUND=0 shares all inputs to exercise truncation.
module tb_dct_mac_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, ena, clr, in_valid;
    logic signed [7:0]  din;
    logic signed [11:0] coef;
    logic               out_valid, ovf, out_valid_t, ovf_t;
    logic signed [11:0] dout, dout_t;

    int n_chk = 0;
    int n_err = 0;
    int edge_n = 0;
    bit en_last = 1'b0;

    typedef struct {int e; int d; bit o; int dt; bit ot;} ev_t;
    ev_t evq[$];

    dct_mac_pipe dut (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .in_valid(in_valid),
        .din(din), .coef(coef), .out_valid(out_valid), .dout(dout), .ovf(ovf)
    );

    dct_mac_pipe #(.ROUND(0)) dut_t (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .in_valid(in_valid),
        .din(din), .coef(coef), .out_valid(out_valid_t), .dout(dout_t), .ovf(ovf_t)
    );

    // Edge counter and the enable that was applied at the latest edge.
    always @(posedge clk) begin
        edge_n  <= edge_n + 1;
        en_last <= ena;
    end

    // Record each genuine result (out_valid produced by an enabled edge).
    always @(negedge clk)
        if (out_valid === 1'b1 && en_last)
            evq.push_back('{edge_n, int'(dout), ovf, int'(dout_t), ovf_t});

    task automatic cyc(input bit e, input bit c, input bit v, input int d, input int k);
        ena = e; clr = c; in_valid = v; din = 8'(d); coef = 12'(k);
        @(posedge clk); #1;
    endtask

    task automatic feed(input int d, input int k, input int n);
        repeat (n) cyc(1, 0, 1, d, k);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0);
    endtask

    // Block result from the exact sum: optional +half, floor divide, clamp.
    function automatic void calc(input longint s, input bit rnd, output int d, output bit o);
        longint r, q;
        r = s + (rnd ? 128 : 0);
        q = (r >= 0) ? r / 256 : -((-r + 255) / 256);
        if (q > 2047) begin d = 2047; o = 1'b1; end
        else if (q < -2048) begin d = -2048; o = 1'b1; end
        else begin d = int'(q); o = 1'b0; end
    endfunction

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; clr = 1'b0; in_valid = 1'b1; din = 8'sd5; coef = 12'sd7;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if (dout !== 12'sd0) begin n_err++; $display("FAIL reset_dout: got %0d want 0", dout); end
        n_chk++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst = 1'b0;
        idle(2);
        evq.delete();
    endtask

    task automatic test_basic();
        int t;
        evq.delete();
        feed(1, 256, 8);
        t = edge_n;
        idle(6);
        n_chk++; if (evq.size() != 1) begin n_err++; $display("FAIL basic_count: got %0d want 1", evq.size()); end
        if (evq.size() > 0) begin
            n_chk++; if (evq[0].e != t + 3) begin n_err++; $display("FAIL basic_latency: got edge %0d want %0d", evq[0].e, t + 3); end
            n_chk++; if (evq[0].d != 8) begin n_err++; $display("FAIL basic_dout: got %0d want 8", evq[0].d); end
            n_chk++; if (evq[0].o != 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b want 0", evq[0].o); end
        end
    endtask

    task automatic test_round();
        int d; bit o;
        evq.delete();
        feed(1, 128, 1); feed(0, 0, 7);
        feed(-1, 128, 1); feed(0, 0, 7);
        idle(6);
        calc(-128, 1'b0, d, o);
        n_chk++; if (evq.size() != 2) begin n_err++; $display("FAIL round_count: got %0d want 2", evq.size()); end
        if (evq.size() > 1) begin
            n_chk++; if (evq[0].d != 1) begin n_err++; $display("FAIL round_half_up: got %0d want 1", evq[0].d); end
            n_chk++; if (evq[0].dt != 0) begin n_err++; $display("FAIL round_trunc: got %0d want 0", evq[0].dt); end
            n_chk++; if (evq[1].d != 0) begin n_err++; $display("FAIL round_neg: got %0d want 0", evq[1].d); end
            n_chk++; if (evq[1].dt != d) begin n_err++; $display("FAIL round_neg_trunc: got %0d want %0d", evq[1].dt, d); end
        end
    endtask

    task automatic test_sat();
        evq.delete();
        feed(127, 2047, 8);
        feed(-128, 2047, 8);
        idle(6);
        n_chk++; if (evq.size() != 2) begin n_err++; $display("FAIL sat_count: got %0d want 2", evq.size()); end
        if (evq.size() > 1) begin
            n_chk++; if (evq[0].d != 2047 || evq[0].o != 1'b1) begin n_err++; $display("FAIL sat_pos: got %0d/%b want 2047/1", evq[0].d, evq[0].o); end
            n_chk++; if (evq[1].d != -2048 || evq[1].o != 1'b1) begin n_err++; $display("FAIL sat_neg: got %0d/%b want -2048/1", evq[1].d, evq[1].o); end
        end
    endtask

    task automatic test_back_to_back();
        int ta;
        evq.delete();
        feed(1, 256, 8);
        ta = edge_n;
        feed(2, 256, 8);
        idle(6);
        n_chk++; if (evq.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", evq.size()); end
        if (evq.size() > 1) begin
            n_chk++; if (evq[0].d != 8 || evq[0].e != ta + 3) begin n_err++; $display("FAIL b2b_a: got %0d@%0d want 8@%0d", evq[0].d, evq[0].e, ta + 3); end
            n_chk++; if (evq[1].d != 16 || evq[1].e != ta + 11) begin n_err++; $display("FAIL b2b_b: got %0d@%0d want 16@%0d", evq[1].d, evq[1].e, ta + 11); end
        end
    endtask

    task automatic test_stall();
        int t0;
        evq.delete();
        feed(1, 256, 1);
        t0 = edge_n;
        feed(1, 256, 3);
        // Stalled cycles offer a term and one clr; neither may take effect.
        cyc(0, 0, 1, 5, 300);
        cyc(0, 1, 1, 5, 300);
        cyc(0, 0, 1, 5, 300);
        cyc(0, 0, 0, 0, 0);
        feed(1, 256, 4);
        idle(6);
        n_chk++; if (evq.size() != 1) begin n_err++; $display("FAIL stall_count: got %0d want 1", evq.size()); end
        if (evq.size() > 0) begin
            n_chk++; if (evq[0].d != 8) begin n_err++; $display("FAIL stall_dout: got %0d want 8", evq[0].d); end
            n_chk++; if (evq[0].e != t0 + 14) begin n_err++; $display("FAIL stall_latency: got edge %0d want %0d", evq[0].e, t0 + 14); end
        end
    endtask

    task automatic test_abort();
        evq.delete();
        feed(3, 256, 3);
        cyc(1, 1, 1, 1, 256);
        feed(1, 256, 7);
        idle(6);
        n_chk++; if (evq.size() != 1) begin n_err++; $display("FAIL abort_count: got %0d want 1", evq.size()); end
        if (evq.size() > 0) begin
            n_chk++; if (evq[0].d != 8) begin n_err++; $display("FAIL abort_dout: got %0d want 8", evq[0].d); end
        end
    endtask

    task automatic test_reset_mid();
        evq.delete();
        feed(1, 256, 5);
        rst = 1'b1;
        cyc(1, 0, 1, 1, 256);
        cyc(1, 1, 1, 1, 256);
        n_chk++; if (out_valid !== 1'b0 || dout !== 12'sd0 || ovf !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs: got %b/%0d/%b want 0/0/0", out_valid, dout, ovf);
        end
        rst = 1'b0;
        feed(1, 256, 8);
        idle(6);
        n_chk++; if (evq.size() != 1) begin n_err++; $display("FAIL rstmid_count: got %0d want 1", evq.size()); end
        if (evq.size() > 0) begin
            n_chk++; if (evq[0].d != 8) begin n_err++; $display("FAIL rstmid_dout: got %0d want 8", evq[0].d); end
        end
    endtask

    task automatic test_random();
        localparam int N = 400;
        bit en[N]; bit vv[N]; int dd[N]; int kk[N];
        ev_t exq[$];
        int base, cnt, j, n, m;
        longint sum;
        ev_t x;
        for (int i = 0; i < N; i++) begin
            en[i] = ($urandom % 8) != 0;
            vv[i] = ($urandom % 4) != 0;
            dd[i] = int'($urandom_range(255)) - 128;
            kk[i] = ($urandom % 2) ? int'($urandom_range(4095)) - 2048 : int'($urandom_range(127)) - 64;
        end
        evq.delete();
        base = edge_n;
        // Model: every 8 accepted terms form a block; its result appears on
        // the third enabled edge after the edge accepting its last term.
        cnt = 0; sum = 0;
        for (int i = 0; i < N; i++) begin
            if (en[i] && vv[i]) begin
                sum = (cnt == 0) ? longint'(dd[i] * kk[i]) : sum + longint'(dd[i] * kk[i]);
                cnt++;
                if (cnt == 8) begin
                    cnt = 0;
                    j = i; n = 0;
                    while (n < 3) begin
                        j++;
                        if (j >= N || en[j]) n++;
                    end
                    x.e = base + 1 + j;
                    calc(sum, 1'b1, x.d, x.o);
                    calc(sum, 1'b0, x.dt, x.ot);
                    exq.push_back(x);
                end
            end
        end
        for (int i = 0; i < N; i++) cyc(en[i], 0, vv[i], dd[i], kk[i]);
        idle(6);
        n_chk++; if (evq.size() != exq.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", evq.size(), exq.size()); end
        m = (evq.size() < exq.size()) ? evq.size() : exq.size();
        for (int i = 0; i < m; i++) begin
            n_chk++; if (evq[i].e != exq[i].e) begin n_err++; $display("FAIL rand_edge[%0d]: got %0d want %0d", i, evq[i].e, exq[i].e); end
            n_chk++; if (evq[i].d != exq[i].d || evq[i].o != exq[i].o) begin n_err++; $display("FAIL rand_round[%0d]: got %0d/%b want %0d/%b", i, evq[i].d, evq[i].o, exq[i].d, exq[i].o); end
            n_chk++; if (evq[i].dt != exq[i].dt || evq[i].ot != exq[i].ot) begin n_err++; $display("FAIL rand_trunc[%0d]: got %0d/%b want %0d/%b", i, evq[i].dt, evq[i].ot, exq[i].dt, exq[i].ot); end
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; clr = 1'b0; in_valid = 1'b0; din = '0; coef = '0;
        test_reset();
        test_basic();
        test_round();
        test_sat();
        test_back_to_back();
        test_stall();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
